// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : Wishbone cycle/burst type encodings and burst-slave FSM states
// Rev 1.0
// ============================================================================
package wb_pkg;

    localparam logic [2:0] c_cti_classic = 3'b000;
    localparam logic [2:0] c_cti_incr    = 3'b010;
    localparam logic [2:0] c_cti_eob     = 3'b111;
    localparam logic [1:0] c_bte_linear  = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        BURST  = 2'd2
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_slv_ram.sv
`default_nettype none
// ============================================================================
// wb_slv_ram : single-port synchronous RAM, byte enables, 1-cycle read latency
// Rev 1.0
// ============================================================================
module wb_slv_ram #(
    parameter int DW         = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DW/8-1:0]       i_sel,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DW-1:0]         i_wdata,
    output logic [DW-1:0]         o_rdata
);

    logic [DW-1:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (i_sel[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/wb_burst_slave.sv
`default_nettype none
// ============================================================================
// wb_burst_slave : Wishbone slave RAM window with classic and wrap-8 INCR bursts
// Optional WB_SLV_ADDR_CHECK_EN: out-of-window accesses terminate with err.
// Rev 1.0
// ============================================================================
module wb_burst_slave
    import wb_pkg::*;
#(
    parameter int            DW        = 32,
    parameter int            AW        = 32,
    parameter int            MEM_LOG2  = 10,
    parameter logic [AW-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);

    wb_state_t             r_state;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_ack_rd;
    logic                  r_oob;
    logic [MEM_LOG2-1:0]   r_cnt;
    logic [DW-1:0]         r_dat_hold;

    logic                  w_req;
    logic                  w_wr;
    logic                  w_oob;
    logic                  w_unused;
    logic [MEM_LOG2-1:0]   w_adr_word;
    logic [MEM_LOG2-1:0]   w_cnt_inc;
    logic [MEM_LOG2-1:0]   w_ram_addr;
    logic [DW-1:0]         w_ram_q;

    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_wr       = r_ack & w_req & wb_we_i;
    assign w_adr_word = wb_adr_i[MEM_LOG2+1:2];
    assign w_cnt_inc  = {r_cnt[MEM_LOG2-1:3], r_cnt[2:0] + 3'd1};
    assign w_unused   = &{1'b0, wb_adr_i};

`ifdef WB_SLV_ADDR_CHECK_EN
    localparam logic [AW:0] c_win_lo = {1'b0, BASE_ADDR};
    localparam logic [AW:0] c_win_hi = c_win_lo + ((AW+1)'(4) << MEM_LOG2);

    assign w_oob = ({1'b0, wb_adr_i} < c_win_lo) || ({1'b0, wb_adr_i} >= c_win_hi);
`else
    assign w_oob = 1'b0;
`endif

    // A read beat being accepted prefetches the next word so every beat
    // has data ready; writes always target the beat currently acked.
    always_comb begin
        w_ram_addr = w_adr_word;
        if (r_state == BURST) begin
            w_ram_addr = (r_ack && !wb_we_i) ? w_cnt_inc : r_cnt;
        end
    end

    wb_slv_ram #(
        .DW         (DW),
        .DEPTH_LOG2 (MEM_LOG2)
    ) u_ram (
        .clk     (wb_clk_i),
        .i_we    (w_wr),
        .i_sel   (wb_sel_i),
        .i_addr  (w_ram_addr),
        .i_wdata (wb_dat_i),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state    <= IDLE;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_ack_rd   <= 1'b0;
            r_oob      <= 1'b0;
            r_cnt      <= '0;
            r_dat_hold <= '0;
        end else begin
            if (r_ack_rd) begin
                r_dat_hold <= w_ram_q;
            end
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_ack_rd <= 1'b0;
            if (!wb_cyc_i) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (wb_stb_i) begin
                            r_oob <= w_oob;
                            if (wb_cti_i == c_cti_incr && wb_bte_i == c_bte_linear) begin
                                r_cnt   <= w_adr_word;
                                r_state <= BURST;
                            end else begin
                                r_state <= SINGLE;
                            end
                        end
                    end
                    SINGLE: begin
                        if (r_ack || r_err) begin
                            r_state <= IDLE;
                        end else if (wb_stb_i) begin
                            r_err    <= r_oob;
                            r_ack    <= !r_oob;
                            r_ack_rd <= !r_oob && !wb_we_i;
                        end
                    end
                    BURST: begin
                        // stb low withholds ack and freezes the beat counter
                        if (r_err) begin
                            r_state <= IDLE;
                        end else if (wb_stb_i) begin
                            if (r_ack) begin
                                if (wb_cti_i == c_cti_eob) begin
                                    r_state <= IDLE;
                                end else begin
                                    r_cnt    <= w_cnt_inc;
                                    r_ack    <= 1'b1;
                                    r_ack_rd <= !wb_we_i;
                                end
                            end else begin
                                r_err    <= r_oob;
                                r_ack    <= !r_oob;
                                r_ack_rd <= !r_oob && !wb_we_i;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign wb_dat_o = r_ack_rd ? w_ram_q : r_dat_hold;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_rty_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_slave.sv
`default_nettype none
// ============================================================================
// tb_wb_burst_slave : randomized bench for wb_burst_slave against a word-array model
// Rev 1.0
// ============================================================================
module tb_wb_burst_slave;

    logic        clk;
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        rty;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] mem_m [1024];
    logic [31:0] last_rd = 32'h0;
    logic [31:0] rd;

    wb_burst_slave #(
        .DW        (32),
        .AW        (32),
        .MEM_LOG2  (10),
        .BASE_ADDR (32'h0000_0000)
    ) u_dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_sel_i   (sel),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_i),
        .wb_cti_i   (cti),
        .wb_bte_i   (bte),
        .wb_dat_o   (dat_o),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .wb_rty_o   (rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // byte address of beat k of a wrap-8 burst: stays inside the 32-byte line
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k);
        return (a & ~32'h1F) | ((a + 32'(4 * k)) & 32'h1F);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    task automatic single(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, input logic oob, output logic [31:0] r);
        int wi;
        wi  = widx(a);
        r   = 32'h0;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_i = d;
        cti = 3'b000; bte = 2'b00;
        tick();
        check("s_early_ack", 32'(ack), 32'd0);
        tick();
        check("s_ack", 32'(ack), oob ? 32'd0 : 32'd1);
        check("s_err", 32'(err), oob ? 32'd1 : 32'd0);
        if (!w && !oob) begin
            check("s_rdata", dat_o, mem_m[wi]);
            r       = dat_o;
            last_rd = mem_m[wi];
        end else begin
            check("s_hold", dat_o, last_rd);
        end
        tick();
        check("s_ack_width", 32'(ack), 32'd0);
        check("s_err_width", 32'(err), 32'd0);
        if (w && !oob) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mem_m[wi][8*b +: 8] = d[8*b +: 8];
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic burst(input logic [31:0] a, input logic w, input int n,
                         input int rst_at, input logic gaps);
        logic [31:0] d [8];
        int          wi;
        for (int k = 0; k < 8; k++) d[k] = $urandom;
        cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; bte = 2'b00;
        adr = beat_addr(a, 0); dat_i = d[0]; cti = (n == 1) ? 3'b111 : 3'b010;
        tick();
        check("b_early_ack", 32'(ack), 32'd0);
        tick();
        for (int k = 0; k < n; k++) begin
            wi = widx(beat_addr(a, k));
            if (gaps && $urandom_range(0, 3) == 0) begin
                stb = 1'b0;
                tick();
                check("b_gap_ack", 32'(ack), 32'd0);
                if (!w) last_rd = mem_m[wi];
                check("b_gap_hold", dat_o, last_rd);
                stb = 1'b1;
                tick();
            end
            check("b_ack", 32'(ack), 32'd1);
            check("b_err", 32'(err), 32'd0);
            if (!w) begin
                check("b_rdata", dat_o, mem_m[wi]);
                last_rd = mem_m[wi];
            end else begin
                check("b_whold", dat_o, last_rd);
            end
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("b_rst_ack", 32'(ack), 32'd0);
                check("b_rst_dat", dat_o, 32'd0);
                last_rd = 32'h0;
                @(posedge clk);
                #1;
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
                rst_n = 1'b1;
                tick();
                return;
            end
            tick();
            if (w) mem_m[wi] = d[k];
            if (k + 1 < n) begin
                adr   = beat_addr(a, k + 1);
                dat_i = d[k + 1];
                cti   = (k + 1 == n - 1) ? 3'b111 : 3'b010;
            end
        end
        check("b_no_extra_ack", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        check("b_idle_hold", dat_o, last_rd);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; dat_i = 32'h0; cti = 3'b000; bte = 2'b00;
        #3;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rty", 32'(rty), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // fill words 0..63 so every later read has a known value
        for (int l = 0; l < 8; l++) burst(32'(l * 32), 1'b1, 8, -1, 1'b0);

        single(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, rd);
        single(32'h10, 1'b0, 4'hF, 32'h0, 1'b0, rd);
        check("classic_rd", rd, 32'hDEADBEEF);

        burst(32'h20, 1'b0, 8, -1, 1'b0);
        burst(32'h38, 1'b0, 8, -1, 1'b0);

        single(32'h40, 1'b1, 4'hF, 32'h11223344, 1'b0, rd);
        single(32'h40, 1'b1, 4'b0100, 32'h00AB0000, 1'b0, rd);
        single(32'h40, 1'b0, 4'hF, 32'h0, 1'b0, rd);
        check("byte_lane_rd", rd, 32'h11AB3344);

        burst(32'h80, 1'b1, 8, 3, 1'b0);
        burst(32'h80, 1'b0, 8, -1, 1'b0);

`ifdef WB_SLV_ADDR_CHECK_EN
        single(32'h0000_1000, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, rd);
        single(32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b1, rd);
        single(32'h0, 1'b0, 4'hF, 32'h0, 1'b0, rd);
`else
        single(32'h0000_1044, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, rd);
        single(32'h44, 1'b0, 4'hF, 32'h0, 1'b0, rd);
        check("alias_rd", rd, 32'hCAFE_F00D);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            ra = 32'($urandom_range(0, 63)) << 2;
            case ($urandom_range(0, 2))
                0: single(ra, 1'b1, 4'($urandom_range(0, 15)), $urandom, 1'b0, rd);
                1: single(ra, 1'b0, 4'hF, 32'h0, 1'b0, rd);
                default: burst(ra, 1'($urandom_range(0, 1)), $urandom_range(2, 8), -1, 1'b1);
            endcase
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_burst_slave.md
WB_BURST_SLAVE -- requirements
Module: wb_burst_slave

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width in bits.
REQ-002 SHALL have parameter AW, default 32, meaning address width in bits.
REQ-003 SHALL have parameter MEM_LOG2, default 10, meaning log2 of word depth.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte base address of the window.
REQ-005 SHALL have port wb_clk_i, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-006 SHALL have port wb_rst_n_i, input, 1, reset, which SHALL be asynchronous and active-low.
REQ-007 SHALL have ports wb_cyc_i and wb_stb_i, each input, 1, meaning cycle valid and strobe.
REQ-008 SHALL have ports wb_we_i, input, 1 (write enable), and wb_sel_i, input, 4 (byte selects).
REQ-009 SHALL have port wb_adr_i, input, AW, meaning byte address; bits [1:0] are ignored.
REQ-010 SHALL have port wb_dat_i, input, DW, meaning write data.
REQ-011 SHALL have ports wb_cti_i, input, 3, and wb_bte_i, input, 2, meaning cycle type and burst type.
REQ-012 SHALL have port wb_dat_o, output, DW, meaning registered read data.
REQ-013 SHALL have ports wb_ack_o, wb_err_o and wb_rty_o, each output, 1, meaning termination flags.

Function
REQ-014 SHALL implement FSM states IDLE, SINGLE and BURST.
REQ-015 SHALL, in IDLE with cyc&stb and cti==3'b010 and bte==2'b00, load the word counter from adr[MEM_LOG2+1:2] and go to BURST; otherwise go to SINGLE when cyc&stb is seen.
REQ-016 SHALL, in SINGLE, assert wb_ack_o for exactly one cycle, exactly 1 cycle after stb is first sampled, then return to IDLE with ack low.
REQ-017 SHALL, in BURST, assert wb_ack_o first 1 cycle after entry and then every cycle while cyc&stb are high (zero wait states).
REQ-018 SHALL, on each burst ack, increment counter bits [2:0] modulo 8, so the burst wraps within a 32-byte line; upper bits SHALL be held.
REQ-019 SHALL return from BURST to IDLE on the cycle after acking a beat with cti==3'b111, with no further ack.
REQ-020 SHALL, if cyc drops in any state, go to IDLE and deassert ack and err on the next edge.
REQ-021 SHALL, if stb drops while cyc is held in BURST, withhold ack and hold the counter until stb returns.
REQ-022 SHALL, on a write, update the RAM on the acked edge using wb_dat_i; only lanes with a set wb_sel_i bit SHALL change.
REQ-023 SHALL present read data in wb_dat_o on the same cycle as its ack; the RAM SHALL prefetch counter+1 during burst so no beat stalls.
REQ-024 SHALL hold wb_dat_o at its last value when ack is low.
REQ-025 SHALL tie wb_rty_o to 0.
REQ-026 SHALL never assert wb_ack_o and wb_err_o in the same cycle.

Reset
REQ-027 SHALL, while wb_rst_n_i=0, force the state to IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0 and counter=0, independent of the clock.
REQ-028 SHALL, on reset mid-burst, abandon the burst; RAM contents SHALL be preserved and only completed acked writes SHALL be retained.

Configuration
REQ-029 SHALL, with WB_SLV_ADDR_CHECK_EN defined, answer accesses outside [BASE_ADDR, BASE_ADDR + 4*2^MEM_LOG2) with wb_err_o (same timing as ack) instead of ack, suppress the write, and return to IDLE after that beat.
REQ-030 SHALL, without WB_SLV_ADDR_CHECK_EN, tie wb_err_o to 0 and decode addresses modulo the RAM depth.

Structure
REQ-031 SHALL place the CTI/BTE encodings (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111, LINEAR 2'b00) and the FSM state enum in the shared package wb_pkg.
REQ-032 SHALL instantiate one sub-module, wb_slv_ram: a single-port synchronous RAM with byte enables and 1-cycle read latency.

Verification
REQ-033 SHALL verify a classic write of 0xDEADBEEF to 0x10 (sel 4'hF) followed by a classic read of 0x10: each ack is 1 cycle wide, 1 cycle after stb, and the read returns 0xDEADBEEF.
REQ-034 SHALL verify an 8-beat INCR read from 0x20 (cti 010 x7, then 111): 8 consecutive acks on back-to-back cycles, words 0x20..0x3C in order, then IDLE with no 9th ack.
REQ-035 SHALL verify a burst starting at 0x38: addresses wrap 0x38, 0x3C, 0x20, ..., 0x34.
REQ-036 SHALL verify a byte write with sel 4'b0100 and data 0x00AB0000 over 0x11223344: a read returns 0x11AB3344.
REQ-037 SHALL verify wb_rst_n_i pulsed low at beat 3 of a write burst: ack drops immediately, beats 0-2 are retained, and beats 3-7 are unchanged.
REQ-038 SHALL verify, with WB_SLV_ADDR_CHECK_EN defined, a classic access to BASE_ADDR+0x1000 (MEM_LOG2=10): err is pulsed 1 cycle, ack stays 0, and memory is unchanged.
